// File: rtl/alu_uart_sequencer.sv
// RX-side sequencer: collects A, B, opcode bytes from UART RX, issues them to the ALU, then waits
// for the TX ack. Optional inter-byte timeout enabled by defining SEQ_TIMEOUT_EN.
module alu_uart_sequencer #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = 6
`ifdef SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_ack,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic               o_alu_valid,
  output logic               o_busy,
  output logic               o_err_op,
  output logic               o_overrun,
  output logic               o_timeout
);

  typedef enum logic [2:0] {StIdle, StGetB, StGetOp, StIssue, StWaitTx} state_e;

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d;
  logic [NB_DATA-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [NB_OP-1:0]   alu_op_q, alu_op_d;
  logic               err_op_q, err_op_d;
  logic               overrun_q, overrun_d;
  logic               expired;
  logic [NB_OP-1:0]   opcode;

  assign opcode = i_rx_data[NB_OP-1:0];

  function automatic logic op_valid(input logic [NB_OP-1:0] op);
    case (op)
      NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100), NB_OP'(6'b100101),
      NB_OP'(6'b100110), NB_OP'(6'b100111), NB_OP'(6'b000011), NB_OP'(6'b000010): op_valid = 1'b1;
      default: op_valid = 1'b0;
    endcase
  endfunction

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            in_frame;
  logic            timeout_q;

  assign in_frame = (state_q == StGetB) || (state_q == StGetOp);
  // A byte arriving in the expiry cycle wins over the timeout.
  assign expired  = in_frame && !i_rx_done && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (in_frame && !i_rx_done && !expired) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= expired;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign expired   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    err_op_d  = 1'b0;
    overrun_d = overrun_q;
    case (state_q)
      StIdle: begin
        if (i_rx_done) begin
          a_d     = i_rx_data;
          state_d = StGetB;
        end
      end
      StGetB: begin
        if (i_rx_done) begin
          b_d     = i_rx_data;
          state_d = StGetOp;
        end else if (expired) begin
          state_d = StIdle;
        end
      end
      StGetOp: begin
        if (i_rx_done) begin
          if (op_valid(opcode)) begin
            alu_a_d  = a_q;
            alu_b_d  = b_q;
            alu_op_d = opcode;
            state_d  = StIssue;
          end else begin
            err_op_d = 1'b1;
            state_d  = StIdle;
          end
        end else if (expired) begin
          state_d = StIdle;
        end
      end
      StIssue: begin
        if (i_rx_done) overrun_d = 1'b1;
        state_d = StWaitTx;
      end
      StWaitTx: begin
        if (i_rx_done) overrun_d = 1'b1;
        if (i_tx_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      err_op_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      err_op_q  <= err_op_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_alu_a     = alu_a_q;
  assign o_alu_b     = alu_b_q;
  assign o_alu_op    = alu_op_q;
  assign o_alu_valid = (state_q == StIssue);
  assign o_busy      = (state_q == StIssue) || (state_q == StWaitTx);
  assign o_err_op    = err_op_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Scoreboard bench for alu_uart_sequencer: directed frames plus random traffic against a
// frame-level reference model.
module tb_alu_uart_sequencer;

  localparam int TO = 16;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic [7:0] i_rx_data = '0;
  logic       i_rx_done = 1'b0;
  logic       i_tx_ack = 1'b0;
  logic [7:0] o_alu_a, o_alu_b;
  logic [5:0] o_alu_op;
  logic       o_alu_valid, o_busy, o_err_op, o_overrun, o_timeout;

  alu_uart_sequencer #(
    .NB_DATA(8),
    .NB_OP  (6)
`ifdef SEQ_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rx_data  (i_rx_data),
    .i_rx_done  (i_rx_done),
    .i_tx_ack   (i_tx_ack),
    .o_alu_a    (o_alu_a),
    .o_alu_b    (o_alu_b),
    .o_alu_op   (o_alu_op),
    .o_alu_valid(o_alu_valid),
    .o_busy     (o_busy),
    .o_err_op   (o_err_op),
    .o_overrun  (o_overrun),
    .o_timeout  (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  // kind: 0 = ALU issue, 1 = bad opcode, 2 = timeout
  typedef struct {
    int         kind;
    int         due;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] frame[$];
  int         phase;     // 0 collecting, 1 issue cycle, 2 waiting for ack
  int         idle_run;
  logic [7:0] exp_a, exp_b;
  logic [5:0] exp_op;
  bit         exp_busy, exp_overrun;
  bit         started = 0;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic [5:0] ops[8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

  function automatic bit is_valid_op(logic [5:0] op);
    return op inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model advanced once per clock edge, with the inputs sampled at that edge.
  task automatic model_cycle(bit rx, logic [7:0] d, bit ack);
    ev_t e;
    if (phase == 1) begin
      if (rx) exp_overrun = 1;
      phase = 2;
    end else if (phase == 2) begin
      if (rx) exp_overrun = 1;
      if (ack) phase = 0;
    end else if (rx) begin
      frame.push_back(d);
      idle_run = 0;
      if (frame.size() == 3) begin
        e.due = cyc + 1;
        if (is_valid_op(d[5:0])) begin
          exp_a  = frame[0];
          exp_b  = frame[1];
          exp_op = d[5:0];
          e.kind = 0; e.a = exp_a; e.b = exp_b; e.op = exp_op;
          phase  = 1;
        end else begin
          e.kind = 1; e.a = '0; e.b = '0; e.op = '0;
        end
        exp_q.push_back(e);
        frame.delete();
      end
    end
`ifdef SEQ_TIMEOUT_EN
    else if (frame.size() > 0) begin
      idle_run++;
      if (idle_run == TO) begin
        frame.delete();
        idle_run = 0;
        e.kind = 2; e.due = cyc + 1; e.a = '0; e.b = '0; e.op = '0;
        exp_q.push_back(e);
      end
    end
`endif
    exp_busy = (phase != 0);
  endtask

  task automatic step(bit rx, logic [7:0] d, bit ack);
    i_rx_done = rx;
    i_rx_data = d;
    i_tx_ack  = ack;
    @(posedge i_clk);
    model_cycle(rx, d, ack);
    #1;
    i_rx_done = 1'b0;
    i_tx_ack  = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send(logic [7:0] d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic do_reset();
    i_rst     = 1'b0;
    i_rx_done = 1'b0;
    i_tx_ack  = 1'b0;
    @(posedge i_clk);
    frame.delete();
    exp_q.delete();
    phase = 0; idle_run = 0;
    exp_a = '0; exp_b = '0; exp_op = '0;
    exp_busy = 0; exp_overrun = 0;
    started = 1;
    #1;
    i_rst = 1'b1;
  endtask

  // Monitor: per-cycle state checks plus pulse matching against the scoreboard queue.
  always @(negedge i_clk) begin
    ev_t e;
    int  k;
    cyc++;
    if (started) begin
      check("busy", o_busy, exp_busy);
      check("overrun", o_overrun, exp_overrun);
      check("alu_a", o_alu_a, exp_a);
      check("alu_b", o_alu_b, exp_b);
      check("alu_op", o_alu_op, exp_op);
`ifndef SEQ_TIMEOUT_EN
      check("timeout_tied", o_timeout, 0);
`endif
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        total++; bad++;
        $display("FAIL missed_pulse kind=%0d due=%0d now=%0d", e.kind, e.due, cyc);
      end
      if (o_alu_valid || o_err_op || o_timeout) begin
        k = o_alu_valid ? 0 : (o_err_op ? 1 : 2);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_pulse kind=%0d at cycle %0d expected none", k, cyc);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", k, e.kind);
          check("pulse_cycle", cyc, e.due);
          if (e.kind == 0) begin
            check("issue_a", o_alu_a, e.a);
            check("issue_b", o_alu_b, e.b);
            check("issue_op", o_alu_op, e.op);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] d;
    do_reset();
    // ADD 5+3, one byte every 10 cycles
    send(8'h05); idle(9); send(8'h03); idle(9); send(8'h20); idle(5);
    step(1'b0, 8'h00, 1'b1); idle(3);
    // invalid opcode, then a normal frame
    send(8'h0F); idle(2); send(8'h01); idle(2); send(8'h3F); idle(3);
    send(8'h10); send(8'h20); send(8'h26); idle(3);
    step(1'b0, 8'h00, 1'b1); idle(2);
    // overrun while waiting, then SUB right after the ack
    send(8'h11); send(8'h22); send(8'h27); idle(2);
    send(8'hAA); idle(2);
    step(1'b0, 8'h00, 1'b1);
    send(8'h08); send(8'h02); send(8'h22); idle(2);
    step(1'b0, 8'h00, 1'b1); idle(2);
    // reset mid-frame
    send(8'h33); send(8'h44);
    do_reset();
    send(8'h01); send(8'h02); send(8'h24); idle(2);
    step(1'b0, 8'h00, 1'b1); idle(2);
    // same-cycle ack and byte, then a new frame; ack during the issue cycle is ignored
    send(8'h01); send(8'h02); send(8'h03); idle(2);
    step(1'b1, 8'h55, 1'b1);
    send(8'h06); send(8'h07); send(8'hC2);
    step(1'b0, 8'h00, 1'b1); idle(3);
    step(1'b0, 8'h00, 1'b1); idle(2);
`ifdef SEQ_TIMEOUT_EN
    do_reset();
    send(8'h07); idle(20);
    send(8'h01); send(8'h01); send(8'h20); idle(2);
    step(1'b0, 8'h00, 1'b1); idle(2);
`endif
    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        d = 8'($urandom);
        if ($urandom_range(0, 1) == 1) d[5:0] = ops[$urandom_range(0, 7)];
        step(($urandom_range(0, 9) < 4), d, ($urandom_range(0, 7) == 0));
      end
    end
    idle(10);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_uart_sequencer.md
Name: alu_uart_sequencer

Overview:
RX-side controller for the UART–ALU–TX loop. It collects a 3-byte command frame from the UART receiver: operand A, then operand B, then the opcode. It validates the opcode, drives the ALU operands and opcode, and pulses the ALU-valid strobe. It then blocks new frames until the TX interface reports that the result has been pushed to the transmitter.

Parameters:
NB_DATA, 8, width of RX bytes and ALU operands
NB_OP, 6, ALU opcode width (low NB_OP bits of the opcode byte)
TIMEOUT_CYCLES, 1000000, inter-byte timeout in clock cycles (used only with SEQ_TIMEOUT_EN)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-low
i_rx_data  in  NB_DATA  byte from UART RX, valid when i_rx_done=1
i_rx_done  in  1  1-cycle pulse, new RX byte
i_tx_ack  in  1  1-cycle pulse from TX interface, result pushed to TX
o_alu_a  out  NB_DATA  operand A to ALU
o_alu_b  out  NB_DATA  operand B to ALU
o_alu_op  out  NB_OP  opcode to ALU
o_alu_valid  out  1  1-cycle strobe, operands/opcode valid (drives ALU done/TX interface)
o_busy  out  1  high while a frame is issued and awaiting i_tx_ack
o_err_op  out  1  1-cycle pulse, invalid opcode, frame discarded
o_overrun  out  1  sticky, RX byte dropped while busy
o_timeout  out  1  1-cycle pulse, frame aborted by timeout

Behaviour:
- Reset (i_rst=0 at posedge): state IDLE; all outputs 0; internal A/B holding registers 0; any partial frame discarded; o_overrun cleared. Reset applies mid-frame and mid-wait identically.
- States: IDLE (wait A), GET_B, GET_OP, ISSUE, WAIT_TX.
- IDLE, i_rx_done=1: latch i_rx_data into A_reg, go to GET_B.
- GET_B, i_rx_done=1: latch into B_reg, go to GET_OP.
- GET_OP, i_rx_done=1, opcode valid:
  - o_alu_a<=A_reg, o_alu_b<=B_reg, o_alu_op<=i_rx_data[NB_OP-1:0], go to ISSUE.
  - Valid opcodes: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 000011 SRA, 000010 SRL.
  - Byte bits above NB_OP are ignored.
- GET_OP, i_rx_done=1, opcode invalid: o_err_op=1 for the next cycle only; go to IDLE; o_alu_* unchanged.
- ISSUE: o_alu_valid=1 for exactly this one cycle; go to WAIT_TX unconditionally.
- WAIT_TX: hold until i_tx_ack=1, then go to IDLE. i_tx_ack in any other state is ignored.
- o_busy=1 in ISSUE and WAIT_TX, else 0; decoded from the state register.
- Latency: opcode byte i_rx_done at cycle N → o_alu_* updated and o_alu_valid=1 in cycle N+1.
- o_alu_a/b/op hold their last issued values until the next valid frame.
- i_rx_done in ISSUE or WAIT_TX: byte dropped; o_overrun<=1, sticky until reset.
- i_rx_done and i_tx_ack in the same WAIT_TX cycle: go to IDLE; byte still dropped; o_overrun set.
- The earliest accepted next byte is one cycle after i_tx_ack.
- i_rx_done with no state change pending has no other effect.

Optional Feature:
Macro SEQ_TIMEOUT_EN.
- Defined:
  - Counter of width $clog2(TIMEOUT_CYCLES) counts cycles in GET_B/GET_OP; it clears on every accepted byte and on entry to GET_B.
  - When the count reaches TIMEOUT_CYCLES-1 with no i_rx_done, go to IDLE, discard the partial frame, and pulse o_timeout for 1 cycle.
  - i_rx_done in the same cycle as expiry wins: byte accepted, no timeout.
- Not defined: no counter; o_timeout tied 0; a partial frame waits indefinitely.

Test Plan:
- Frame 0x05, 0x03, 0x20 (ADD), one byte every 10 cycles → o_alu_a=0x05, o_alu_b=0x03, o_alu_op=6'b100000, o_alu_valid high one cycle, the cycle after the third i_rx_done; o_busy=1 until i_tx_ack, then 0.
- Frame 0x0F, 0x01, 0x3F (invalid) → o_err_op one-cycle pulse, o_alu_valid never asserts, o_alu_* keep previous values, next frame accepted normally.
- During WAIT_TX send byte 0xAA → o_overrun=1 and stays 1; after i_tx_ack, frame 0x08, 0x02, 0x22 issues SUB with a=0x08, b=0x02.
- Reset asserted after two bytes of a frame → all outputs 0; a following full frame 0x01, 0x02, 0x24 issues AND with a=0x01, b=0x02.
- Same-cycle i_tx_ack and i_rx_done in WAIT_TX → state IDLE, byte dropped, o_overrun=1; the next three bytes form a new frame.
- SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=16: send 0x07, then idle 20 cycles → o_timeout pulse at the 16th idle cycle; next bytes 0x01, 0x01, 0x20 issue a=0x01, b=0x01 (0x07 discarded).
